// File: rtl/solver_pkg.sv
// Shared constants and types for the block_solver host front end.
// Status codes, solver state codes and packet sizes live here.
package solver_pkg;

    localparam int WORK_BYTES   = 76;
    localparam int WORK_BITS    = WORK_BYTES * 8;
    localparam int RESULT_BYTES = 5;
    localparam int RESULT_BITS  = RESULT_BYTES * 8;

    localparam logic [2:0] SOLVER_FOUND     = 3'h2;
    localparam logic [2:0] SOLVER_EXHAUSTED = 3'h3;

    localparam logic [7:0] STATUS_FOUND     = 8'h01;
    localparam logic [7:0] STATUS_EXHAUSTED = 8'h02;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_REPORT
    } ctrl_state_t;

endpackage

// File: rtl/result_serializer.sv
// Shifts a captured {status, nonce} word out MSB-first over valid/ready.
// The shift register doubles as the result register of the controller.
module result_serializer
    import solver_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic [RESULT_BITS-1:0] i_data,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [7:0]             o_data,
    output logic                   o_done
);

    logic [RESULT_BITS-1:0] r_shift;
    logic [2:0]             r_cnt;
    logic                   r_valid;
    logic                   w_fire;
    logic                   w_last;

    assign w_fire  = r_valid && i_ready;
    assign w_last  = (r_cnt == 3'(RESULT_BYTES - 1));
    assign o_valid = r_valid;
    assign o_data  = r_shift[RESULT_BITS-1 -: 8];
    assign o_done  = w_fire && w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_shift <= {r_shift[RESULT_BITS-9:0], 8'h00};
            r_cnt   <= r_cnt + 3'd1;
            if (w_last) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/solver_work_controller.sv
// Host-side front end for block_solver: loads a 76-byte work packet,
// runs the solver until found/exhausted, then returns a 5-byte result.
module solver_work_controller
    import solver_pkg::*;
#(
    parameter int RST_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         solver_rst_n,
    output logic [255:0] midstate,
    output logic [255:0] target,
    output logic [95:0]  header_leftovers,
    input  logic [2:0]   solver_state,
    input  logic [31:0]  solver_nonce,
    output logic         busy
);

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    ctrl_state_t          r_state;
    ctrl_state_t          w_next;
    logic [WORK_BITS-1:0] r_work;
    logic [6:0]           r_byte_cnt;
    logic [CW-1:0]        r_rst_cnt;
    logic                 r_settled;

    logic                 w_accept;
    logic                 w_last_byte;
    logic                 w_start_done;
    logic                 w_capture;
    logic [7:0]           w_status;
    logic                 w_ser_done;

    assign rx_ready     = rst_n && (r_state == ST_LOAD);
    assign w_accept     = rx_ready && rx_valid;
    assign w_last_byte  = (r_byte_cnt == 7'(WORK_BYTES - 1));
    assign w_start_done = (r_rst_cnt == CW'(RST_CYCLES - 1));

    // r_settled masks the first RUN cycle while the solver leaves reset
    assign w_capture = (r_state == ST_RUN) && r_settled &&
                       ((solver_state == SOLVER_FOUND) ||
                        (solver_state == SOLVER_EXHAUSTED));
    assign w_status  = (solver_state == SOLVER_FOUND) ?
                       STATUS_FOUND : STATUS_EXHAUSTED;

    assign solver_rst_n     = (r_state == ST_RUN);
    assign busy             = (r_state != ST_LOAD);
    assign midstate         = r_work[WORK_BITS-1 -: 256];
    assign target           = r_work[351:96];
    assign header_leftovers = r_work[95:0];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_LOAD: begin
                if (w_accept && w_last_byte) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (w_start_done) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_capture) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (w_ser_done) begin
                    w_next = ST_LOAD;
                end
            end
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_work     <= '0;
            r_byte_cnt <= '0;
            r_rst_cnt  <= '0;
            r_settled  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_settled <= (r_state == ST_RUN);
            if (w_accept) begin
                r_work     <= {r_work[WORK_BITS-9:0], rx_data};
                r_byte_cnt <= w_last_byte ? 7'd0 : r_byte_cnt + 7'd1;
            end
            if ((r_state == ST_START) && !w_start_done) begin
                r_rst_cnt <= r_rst_cnt + CW'(1);
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    result_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_capture),
        .i_data  ({w_status, solver_nonce}),
        .i_ready (tx_ready),
        .o_valid (tx_valid),
        .o_data  (tx_data),
        .o_done  (w_ser_done)
    );

endmodule

// File: tb/tb_solver_work_controller.sv
// Self-checking bench for solver_work_controller with a behavioural
// solver stand-in and a scoreboard of expected result bytes.
module tb_solver_work_controller;
    import solver_pkg::*;

    localparam int RST_CYCLES = 2;

    localparam logic [607:0] KNOWN_WORK = {
        256'h4a03aeb2_3f1c9e07_61b0d4a8_92e5c713_0bf86a2d_7c4e19f5_a6d2308b_ddef7254,
        256'h00000000_00000000_0440C400_00000000_00000000_00000000_00000000_00000000,
        96'h15274c646c51f957c4400418
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         solver_rst_n;
    logic [255:0] midstate;
    logic [255:0] target;
    logic [95:0]  header_leftovers;
    logic [2:0]   solver_state;
    logic [31:0]  solver_nonce;
    logic         busy;

    always #5 clk = ~clk;

    solver_work_controller #(.RST_CYCLES(RST_CYCLES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .solver_rst_n     (solver_rst_n),
        .midstate         (midstate),
        .target           (target),
        .header_leftovers (header_leftovers),
        .solver_state     (solver_state),
        .solver_nonce     (solver_nonce),
        .busy             (busy)
    );

    typedef struct {
        logic [607:0] work;
        int           gap;
        int           hold;
        int           run;
        logic [2:0]   code;
        logic [31:0]  nonce;
        logic [7:0]   status;
        bit           glitch;
        int           abort_at;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         tx_seen = 0;
    logic [7:0] sb[$];
    vec_t       vecs[6];

    always @(negedge clk) begin
        if (tx_valid === 1'b1) tx_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [607:0] act,
                       input logic [607:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [607:0] rnd_work();
        logic [607:0] w;
        w = '0;
        for (int i = 0; i < 19; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        rx_valid     = 1'b0;
        tx_ready     = 1'b0;
        solver_state = 3'h0;
        @(negedge clk);
        chk("rst solver_rst_n", solver_rst_n, 1'b0);
        chk("rst rx_ready", rx_ready, 1'b0);
        chk("rst tx_valid", tx_valid, 1'b0);
        chk("rst tx_data", tx_data, 8'h00);
        chk("rst busy", busy, 1'b0);
        chk("rst work", {midstate, target, header_leftovers}, 608'h0);
        rst_n = 1'b1;
        sb.delete();
        #1;
        chk("rx_ready after reset", rx_ready, 1'b1);
    endtask

    task automatic load_packet(input logic [607:0] w, input int gap,
                               input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            int g;
            g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            rx_valid = 1'b0;
            repeat (g) @(negedge clk);
            rx_data  = w[607-8*i -: 8];
            rx_valid = 1'b1;
            if (i == WORK_BYTES - 1) begin
                chk("busy during load", busy, 1'b0);
                chk("rx_ready during load", rx_ready, 1'b1);
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_release(output int k);
        k = 1;
        while (solver_rst_n !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vector(input vec_t v);
        int         k;
        int         got;
        int         n;
        int         hold_cnt;
        bit         held;
        logic [7:0] prev;
        logic [7:0] e;
        prev = 8'h00;
        load_packet(v.work, v.gap, WORK_BYTES);
        chk("busy after load", busy, 1'b1);
        chk("rx_ready after load", rx_ready, 1'b0);
        rx_data  = 8'hee;
        rx_valid = 1'b1;
        wait_release(k);
        rx_valid = 1'b0;
        chk("release latency", k, RST_CYCLES + 1);
        chk("work regs", {midstate, target, header_leftovers}, v.work);
        solver_state = v.glitch ? SOLVER_FOUND : 3'h1;
        solver_nonce = ~v.nonce;
        for (int c = 0; c < v.run; c++) begin
            @(negedge clk);
            chk("no early tx", tx_valid, 1'b0);
            solver_state = 3'h1;
            solver_nonce = 32'(c);
        end
        solver_state = v.code;
        solver_nonce = v.nonce;
        sb.push_back(v.status);
        for (int b = 3; b >= 0; b--) sb.push_back(v.nonce[8*b +: 8]);
        @(negedge clk);
        solver_state = 3'h0;
        solver_nonce = 32'h0;
        chk("tx latency", tx_valid, 1'b1);
        chk("solver held in report", solver_rst_n, 1'b0);
        got      = 0;
        n        = 0;
        hold_cnt = 0;
        while (got < RESULT_BYTES && n < 200) begin
            if (v.abort_at > 0 && got == v.abort_at) break;
            held = 1'b0;
            if (tx_valid !== 1'b1) begin
                tx_ready = 1'b0;
            end else if (hold_cnt < v.hold) begin
                tx_ready = 1'b0;
                hold_cnt++;
                prev = tx_data;
                held = 1'b1;
            end else begin
                tx_ready = 1'b1;
                e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
                chk("tx byte", tx_data, e);
                got++;
                hold_cnt = 0;
            end
            @(negedge clk);
            n++;
            tx_ready = 1'b0;
            if (held) chk("tx stable", {tx_valid, tx_data}, {1'b1, prev});
        end
        if (v.abort_at > 0) begin
            chk("bytes before abort", got, v.abort_at);
            do_reset();
            return;
        end
        chk("tx byte count", got, RESULT_BYTES);
        chk("tx cycles", n, RESULT_BYTES * (v.hold + 1));
        chk("tx_valid low after last", tx_valid, 1'b0);
        chk("back in LOAD", rx_ready, 1'b1);
        chk("busy low after report", busy, 1'b0);
        chk("scoreboard empty", sb.size(), 0);
        chk("work kept", {midstate, target, header_leftovers}, v.work);
    endtask

    initial begin
        int           k;
        int           tx_base;
        logic [607:0] wnew;
        rst_n        = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        tx_ready     = 1'b0;
        solver_state = 3'h0;
        solver_nonce = 32'h0;
        @(negedge clk);
        do_reset();

        vecs[0] = '{work: KNOWN_WORK, gap: 0, hold: 0, run: 3, code: SOLVER_FOUND,
                    nonce: 32'h9c9a4fc0, status: 8'h01, glitch: 1'b0, abort_at: 0};
        vecs[1] = '{work: KNOWN_WORK, gap: 0, hold: 0, run: 5, code: SOLVER_EXHAUSTED,
                    nonce: 32'hffffffff, status: 8'h02, glitch: 1'b0, abort_at: 0};
        vecs[2] = '{work: rnd_work(), gap: 0, hold: 10, run: 2, code: SOLVER_FOUND,
                    nonce: 32'h12345678, status: 8'h01, glitch: 1'b1, abort_at: 0};
        vecs[3] = '{work: rnd_work(), gap: 5, hold: 1, run: 1, code: SOLVER_EXHAUSTED,
                    nonce: 32'ha5a50f0f, status: 8'h02, glitch: 1'b0, abort_at: 0};
        vecs[4] = '{work: rnd_work(), gap: 2, hold: 0, run: 2, code: SOLVER_FOUND,
                    nonce: 32'hdeadbeef, status: 8'h01, glitch: 1'b0, abort_at: 2};
        vecs[5] = '{work: KNOWN_WORK, gap: 3, hold: 2, run: 4, code: SOLVER_FOUND,
                    nonce: 32'h9c9a4fc0, status: 8'h01, glitch: 1'b1, abort_at: 0};

        foreach (vecs[i]) run_vector(vecs[i]);

        tx_base = tx_seen;
        load_packet(rnd_work(), 1, 40);
        do_reset();
        wnew = rnd_work();
        load_packet(wnew, 0, WORK_BYTES);
        chk("reload regs", {midstate, target, header_leftovers}, wnew);
        wait_release(k);
        chk("release after reload", k, RST_CYCLES + 1);
        solver_state = 3'h1;
        repeat (3) @(negedge clk);
        do_reset();
        chk("no tx during reload", tx_seen - tx_base, 0);

        run_vector(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/solver_work_controller.md
Name: solver_work_controller

Overview:
Host-side front end for block_solver.
- Receives a 76-byte work packet over a byte stream (valid/ready) and drives midstate, target and header_leftovers into the solver.
- Holds the solver in reset while loading, then releases it and monitors solver state until it reports found or exhausted.
- Returns a 5-byte result packet (status + nonce) on an outbound byte stream.
- Sits between the host link (UART/SPI byte layer) and block_solver, whose rst_n and outputs it owns.

Parameters:
RST_CYCLES, 2, cycles solver_rst_n is held low after the last work byte before release (min 1)
WORK_BYTES, 76, work packet length: 32 midstate + 32 target + 12 leftovers (fixed; localparam in package)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
rx_data  in  8  inbound work byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  controller accepts byte this cycle
tx_data  out  8  outbound result byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte this cycle
solver_rst_n  out  1  drives block_solver rst_n
midstate  out  256  to solver
target  out  256  to solver
header_leftovers  out  96  to solver
solver_state  in  3  block_solver state_out; 3'h2 = found, 3'h3 = exhausted, other values = still running
solver_nonce  in  32  block_solver current_nonce
busy  out  1  high in every state except LOAD

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state=LOAD, byte_cnt=0, rst_cnt=0.
  - solver_rst_n=0, rx_ready=0 during reset, tx_valid=0, tx_data=0, busy=0.
  - midstate/target/header_leftovers=0; result registers=0.
- Work buffer is a 608-bit shift register {midstate,target,header_leftovers}.
  - An accepted byte shifts in at bits [7:0]; prior contents shift up 8.
  - After 76 bytes, byte 0 occupies [607:600] (MSB of midstate) and byte 75 occupies header_leftovers[7:0].
- LOAD:
  - rx_ready=1, solver_rst_n=0.
  - Accept on rx_valid&&rx_ready; byte_cnt increments.
  - On acceptance of byte 75, go to START; byte_cnt clears.
  - rx_valid gaps are allowed: no timeout, partial packet is held.
- START:
  - rx_ready=0, solver_rst_n=0; rst_cnt counts up.
  - After exactly RST_CYCLES cycles in START, go to RUN.
- RUN:
  - solver_rst_n=1, rx_ready=0.
  - The first RUN cycle ignores solver_state (solver settling); from the second cycle on, sample solver_state every cycle.
  - solver_state==2: capture status=8'h01 and nonce=solver_nonce; go to REPORT the next cycle.
  - solver_state==3: capture status=8'h02 and the nonce; go to REPORT.
  - Capture happens on the same edge the state code is first seen.
- REPORT:
  - solver_rst_n=0, so the solver is frozen and the outputs are stable.
  - Emits 5 bytes: status, nonce[31:24], [23:16], [15:8], [7:0].
  - tx_valid=1 with tx_data held stable until tx_ready; advance one byte per handshake.
  - Back-to-back bytes when tx_ready is held high: 5 cycles total.
  - After the 5th handshake, tx_valid=0 the next cycle and state goes to LOAD.
  - Work registers keep their last values until overwritten by the next load.
- Latency:
  - Last rx byte accepted at cycle N → solver_rst_n rises at N+1+RST_CYCLES.
  - found/exhausted seen at cycle M → tx_valid=1 at M+1.
- rx bytes presented outside LOAD are not accepted (rx_ready=0); the sender must hold them.
- Reset mid-packet or mid-run: the partial packet and any result are discarded, and the solver is held in reset.

Decomposition:
- Package solver_pkg holds:
  - the state enum (LOAD, START, RUN, REPORT);
  - SOLVER_FOUND=3'h2 and SOLVER_EXHAUSTED=3'h3;
  - STATUS_FOUND=8'h01 and STATUS_EXHAUSTED=8'h02;
  - WORK_BYTES=76 and RESULT_BYTES=5.
- One natural sub-module: result_serializer. It loads a 40-bit {status,nonce}, shifts it out MSB-first over valid/ready, and pulses done.
- The work shift register stays inline.

Test Plan:
1. Known-solution work: midstate 4a03aeb2…ddef7254, target 00000000000000000440C400…00, leftovers 15274c646c51f957c4400418. Feed 76 bytes to a real block_solver with nonce forced to 9c9a4fc0, then check:
   - outputs equal these vectors;
   - tx sequence is 01 9c 9a 4f c0;
   - busy drops after the last byte.
2. Same work with the nonce forced to fffffff0 (exhaustion) → status byte 02 followed by the 4 captured nonce bytes. The controller then returns to LOAD with rx_ready=1.
3. tx backpressure: hold tx_ready=0 for 10 cycles per byte → tx_data stable while valid; exactly 5 bytes; no duplicates or drops.
4. rx gaps: insert random 0-5 cycle gaps in rx_valid → identical outputs and timing relative to the last byte. Also check solver_rst_n rises exactly RST_CYCLES+1 cycles after the final accept.
5. Reset mid-load after 40 bytes, then a full clean 76-byte load → registers contain only the new packet; no tx activity.
6. Reset during RUN and during REPORT byte 3 → tx_valid=0 and solver_rst_n=0 on the next edge; state LOAD; busy=0.
